// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the RISC-V fetch stage.
//
// Holds the architectural fetch PC and issues one fetch request per cycle
// while running. Next-PC selection priority, highest first:
// reset, trap, redirect (aligned), misaligned-redirect reject,
// sequential advance on an accepted fetch, hold.
// A BOOT/RUN/HALT state machine gates fetch issue.
//
// Parameters:
//   PC_WIDTH      width of every address port
//   RESET_VECTOR  value loaded into pc_o by reset
//   INST_BYTES    sequential step in bytes (2 or 4)
//
// Ports:
//   clk                clock, rising edge
//   rst                synchronous active-high reset
//   stall_i            pipeline stall, blocks sequential advance
//   fetch_ready_i      instruction memory accepts the current request
//   redirect_valid_i   branch/jump taken (from EX)
//   redirect_target_i  redirect destination
//   trap_valid_i       trap/exception entry
//   trap_vector_i      trap handler address (low ALIGN bits ignored)
//   halt_i             level-sensitive request to stop fetching
//   pc_o               current fetch address (registered)
//   pc_plus_o          pc_o + INST_BYTES (combinational, wraps)
//   fetch_valid_o      fetch request valid (registered)
//   misalign_o         one-cycle pulse: redirect rejected as misaligned
//   bad_target_o       last rejected redirect target
//   halted_o           state is HALT

module pc_gen #(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                   INST_BYTES   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                fetch_ready_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_target_i,
    input  logic                trap_valid_i,
    input  logic [PC_WIDTH-1:0] trap_vector_i,
    input  logic                halt_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus_o,
    output logic                fetch_valid_o,
    output logic                misalign_o,
    output logic [PC_WIDTH-1:0] bad_target_o,
    output logic                halted_o
);

    localparam int ALIGN = (INST_BYTES == 2) ? 1 : 2;

    localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INST_BYTES);
    // Clears the low ALIGN bits of an address.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INST_BYTES - 1);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic                misalign_next;
    logic [PC_WIDTH-1:0] bad_target_next;
    logic                accept;
    logic                redirect_aligned;

    assign accept           = fetch_valid_o & fetch_ready_i & ~stall_i;
    assign redirect_aligned = (redirect_target_i[ALIGN-1:0] == '0);
    assign pc_plus_o        = pc_o + PC_INC;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_next      = state;
        pc_next         = pc_o;
        misalign_next   = 1'b0;
        bad_target_next = bad_target_o;

        if (trap_valid_i) begin
            pc_next    = trap_vector_i & ALIGN_MASK;
            state_next = S_RUN;
        end else if (redirect_valid_i) begin
            if (redirect_aligned) begin
                // Taken regardless of stall/ready: the in-flight request is dropped.
                pc_next    = redirect_target_i;
                state_next = S_RUN;
            end else begin
                // Rejected: PC and state are frozen, only the error is recorded.
                misalign_next   = 1'b1;
                bad_target_next = redirect_target_i;
            end
        end else begin
            case (state)
                S_BOOT: state_next = S_RUN;
                S_RUN: begin
                    // Halt takes precedence over the advance on the same edge.
                    if (halt_i) begin
                        state_next = S_HALT;
                    end else if (accept) begin
                        pc_next = pc_o + PC_INC;
                    end
                end
                S_HALT: begin
                    if (!halt_i) begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state         <= S_BOOT;
            pc_o          <= RESET_VECTOR;
            fetch_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            bad_target_o  <= '0;
            halted_o      <= 1'b0;
        end else begin
            state         <= state_next;
            pc_o          <= pc_next;
            // Registered from the next state so they always match 'state'.
            fetch_valid_o <= (state_next == S_RUN);
            halted_o      <= (state_next == S_HALT);
            misalign_o    <= misalign_next;
            bad_target_o  <= bad_target_next;
        end
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V pipeline fetch stage. It holds the architectural fetch PC and produces a fetch request each cycle. It applies next-PC selection with fixed priority: reset, trap, redirect, stall/backpressure, sequential increment. A small boot/run/halt state machine gates fetch issue. It sits between the fetch-stage instruction memory port and the EX-stage branch/jump and trap logic.

## Interface
Parameters:
- PC_WIDTH, 32, width of every address port.
- RESET_VECTOR, 0, value loaded into pc_o by reset.
- INST_BYTES, 4, sequential step in bytes; legal values are 2 or 4. ALIGN = log2(INST_BYTES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  pipeline stall; blocks sequential advance.
- fetch_ready_i  in  1  instruction memory accepts the current request.
- redirect_valid_i  in  1  branch/jump taken, from EX.
- redirect_target_i  in  PC_WIDTH  redirect destination.
- trap_valid_i  in  1  trap/exception entry.
- trap_vector_i  in  PC_WIDTH  trap handler address; low ALIGN bits are ignored and treated as 0.
- halt_i  in  1  request to stop fetching; level-sensitive.
- pc_o  out  PC_WIDTH  current fetch address; registered.
- pc_plus_o  out  PC_WIDTH  pc_o + INST_BYTES, modulo 2^PC_WIDTH; combinational.
- fetch_valid_o  out  1  fetch request valid; registered.
- misalign_o  out  1  one-cycle pulse; a redirect was rejected as misaligned.
- bad_target_o  out  PC_WIDTH  rejected redirect target; held until the next rejection.
- halted_o  out  1  state is HALT.

## Operation
- **States:** BOOT, RUN, HALT.
- **Reset values:** state=BOOT, pc_o=RESET_VECTOR, fetch_valid_o=0, misalign_o=0, bad_target_o=0, halted_o=0.
- **Fetch acceptance:** accept = fetch_valid_o & fetch_ready_i & ~stall_i.
- **Next-PC priority, highest first:**
  1. rst: load reset values.
  2. trap_valid_i, any state: pc_o <= {trap_vector_i[PC_WIDTH-1:ALIGN], ALIGN'b0}; state <= RUN.
  3. redirect_valid_i with target[ALIGN-1:0]==0, any state: pc_o <= target; state <= RUN. A redirect applies regardless of stall_i and fetch_ready_i; the in-flight request is discarded.
  4. redirect_valid_i with misaligned target: pc_o holds; misalign_o <= 1 for one cycle; bad_target_o <= target; state unchanged.
  5. RUN & accept: pc_o <= pc_o + INST_BYTES. At the maximum address this wraps to 0, with no flag.
  6. Otherwise pc_o holds.
- **State transitions without trap or redirect:**
  - BOOT -> RUN after one cycle, unconditionally. This gives one bubble after reset.
  - RUN -> HALT when halt_i=1. The PC is not advanced that edge, even if accept=1.
  - HALT -> RUN when halt_i=0.
- **fetch_valid_o:** 1 only while state=RUN. It is registered from the next state, so it is 0 in the cycle after entering HALT.
- **Simultaneous events:**
  - trap and redirect on the same edge: trap wins.
  - redirect and halt_i on the same edge: redirect wins and state=RUN. halt_i still high then moves the block to HALT on the following edge.
  - A trap or redirect arriving during BOOT skips the bubble.

## Timing
- All outputs are registered except pc_plus_o.
- **Redirect latency:**
  - redirect_valid_i sampled at edge N gives pc_o=target and fetch_valid_o=1 after edge N.
  - This holds even when the block was in HALT before edge N.
- **Stalled request:** a request held by stall_i or by fetch_ready_i=0 keeps pc_o and fetch_valid_o stable until accepted or redirected.
- **Reset mid-operation:** a reset at any edge overrides all inputs that edge and restores the reset values. The first fetch_valid_o=1 appears two edges after rst is released.

## Test plan
- **Reset and boot:** RESET_VECTOR=0x100, rst high 2 cycles, then fetch_ready_i=1.
  - Cycle after release: pc_o=0x100, fetch_valid_o=0.
  - Then pc_o=0x100 with fetch_valid_o=1, followed by 0x104 and 0x108.
- **Backpressure and stall:** in RUN at pc 0x20, fetch_ready_i=0 for 3 cycles, then stall_i=1 for 2 cycles.
  - pc_o stays 0x20 with fetch_valid_o=1 throughout.
  - Advances to 0x24 after both are clear.
- **Redirect under stall:** stall_i=1, redirect to 0x400.
  - pc_o=0x400 next cycle.
  - A misaligned redirect to 0x402 (INST_BYTES=4) leaves pc_o unchanged, pulses misalign_o for 1 cycle, and sets bad_target_o=0x402.
- **Priority:** trap_vector_i=0x803 and redirect to 0x500 on the same edge.
  - pc_o=0x800, state RUN.
- **Halt:** halt_i=1 at pc 0x40.
  - halted_o=1, fetch_valid_o=0, pc_o=0x40 held.
  - halt_i=0 resumes at 0x40.
  - A redirect to 0x60 while halted gives RUN with pc_o=0x60.
- **Wrap and compressed step:** INST_BYTES=2, redirect to 0xFFFF_FFFE, accept.
  - pc_o=0x0000_0000.
  - pc_plus_o=0x0000_0000 while pc_o=0xFFFF_FFFE.
